fix_to_float: RTL and testbench

- Sequential converter from signed two's-complement fixed-point to IEEE-754-style binary floating-point (binary16 by default).
- It is the inverse path of the float-to-fixed datapath and uses the same fixed-point scaling: fixed LSB weight equals the smallest subnormal, 2^-24 for binary16.
- Normalization is iterative, one left-shift per cycle, followed by a round-to-nearest-even stage.
- Input and output each use a valid/ready handshake, so the block sits between a fixed-point accumulator and a float result bus.

---
 rtl/fix_to_float_if.sv | 24 ++
 rtl/fix_to_float.sv | 118 +++++++++++
 tb/tb_fix_to_float.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fix_to_float_if.sv
// rtl/fix_to_float_if.sv - operand/result handshake bundle for fix_to_float
interface fix_to_float_if #(
  parameter int FIXED_OP_WIDTH = 40,
  parameter int FLOAT_OP_WIDTH = 16
);
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [FIXED_OP_WIDTH-1:0] fixed_point_value_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [FLOAT_OP_WIDTH-1:0] float_point_value_o;
  logic                      inexact_flag_o;
  logic                      overflow_flag_o;

  modport master (
    output in_valid_i, fixed_point_value_i, out_ready_i,
    input  in_ready_o, out_valid_o, float_point_value_o, inexact_flag_o, overflow_flag_o
  );

  modport slave (
    input  in_valid_i, fixed_point_value_i, out_ready_i,
    output in_ready_o, out_valid_o, float_point_value_o, inexact_flag_o, overflow_flag_o
  );
endinterface

// File: rtl/fix_to_float.sv
// rtl/fix_to_float.sv - signed fixed-point to binary float converter
// Magnitude is normalized one bit per cycle, then rounded to nearest-even.
module fix_to_float #(
  parameter int FIXED_OP_WIDTH = 40,
  parameter int FLOAT_OP_WIDTH = 16,
  parameter int EXP_MSB_POS    = 14,
  parameter int EXP_LSB_POS    = 10
) (
  input logic          clk_i,
  input logic          rst_i,
  fix_to_float_if.slave bus
);
  localparam int W  = FIXED_OP_WIDTH;
  localparam int MW = EXP_LSB_POS;
  localparam int EW = EXP_MSB_POS - EXP_LSB_POS + 1;
  localparam int PW = $clog2(W) + 1;
  localparam int XW = ((PW > EW) ? PW : EW) + 1;
  localparam logic [XW-1:0] EMAX = XW'((1 << EW) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                    state_q;
  logic                      sign_q;
  logic [W-1:0]              sh_q;
  logic [PW-1:0]             p_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [FLOAT_OP_WIDTH-1:0] float_q;
  logic                      inexact_q;
  logic                      overflow_q;

  logic [MW-1:0]             mant;
  logic                      guard;
  logic                      sticky;
  logic                      inc;
  logic [XW-1:0]             e_pre;
  logic [XW+MW-1:0]          sum;
  logic [XW-1:0]             e_res;
  logic                      ovf_d;
  logic [FLOAT_OP_WIDTH-1:0] float_d;
  logic                      stop;

  // Zero stops immediately like a pre-normalized operand, so latency stays S+2.
  assign stop = sh_q[W-1] | (p_q == PW'(MW)) | ~(|sh_q);

  always_comb begin
    mant   = sh_q[W-2 -: MW];
    guard  = sh_q[W-2-MW];
    sticky = |sh_q[W-3-MW:0];
    e_pre  = sh_q[W-1] ? (XW'(p_q) - XW'(MW - 1)) : '0;
    inc    = guard & (sticky | mant[0]);
    // Mantissa carry ripples straight into the exponent field.
    sum    = {e_pre, mant} + (XW+MW)'(inc);
    e_res  = sum[MW +: XW];
    ovf_d  = (e_res >= EMAX);
    if (ovf_d) begin
      float_d = FLOAT_OP_WIDTH'({sign_q, {EW{1'b1}}, {MW{1'b0}}});
    end else begin
      float_d = FLOAT_OP_WIDTH'({sign_q, e_res[EW-1:0], sum[MW-1:0]});
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      sh_q        <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      float_q     <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            sign_q     <= bus.fixed_point_value_i[W-1];
            sh_q       <= bus.fixed_point_value_i[W-1] ? -bus.fixed_point_value_i
                                                        :  bus.fixed_point_value_i;
            p_q        <= PW'(W - 1);
            in_ready_q <= 1'b0;
            state_q    <= NORM;
          end
        end
        NORM: begin
          if (stop) begin
            state_q <= ROUND;
          end else begin
            sh_q <= sh_q << 1;
            p_q  <= p_q - 1'b1;
          end
        end
        ROUND: begin
          float_q     <= float_d;
          inexact_q   <= guard | sticky;
          overflow_q  <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o          = in_ready_q;
  assign bus.out_valid_o         = out_valid_q;
  assign bus.float_point_value_o = float_q;
  assign bus.inexact_flag_o      = inexact_q;
  assign bus.overflow_flag_o     = overflow_q;
endmodule

// File: tb/tb_fix_to_float.sv
// tb/tb_fix_to_float.sv - scoreboard bench for fix_to_float
module tb_fix_to_float;
  localparam int W    = 40;
  localparam int FW   = 16;
  localparam int MW   = 10;
  localparam int EW   = 5;
  localparam longint EMAX = (64'd1 << EW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fix_to_float_if #(.FIXED_OP_WIDTH(W), .FLOAT_OP_WIDTH(FW)) bus_if ();

  fix_to_float #(
    .FIXED_OP_WIDTH(W), .FLOAT_OP_WIDTH(FW), .EXP_MSB_POS(14), .EXP_LSB_POS(10)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  typedef struct {
    logic [FW-1:0] val;
    bit            inex;
    bit            ovf;
    longint        lat;
    longint        acc;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  bit     seen = 0;
  longint rise = 0;
  int     hold = 0;
  bit     hold_req = 0;
  bit     chk_rdy = 0;
  bit     rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: value = x * 2^-24, rounded to MW fraction bits, ties to even.
  function automatic exp_t model(input logic [W-1:0] x);
    exp_t            r;
    bit              neg;
    longint unsigned mag, kept, rem, half, field;
    int              lead, sft;
    neg  = x[W-1];
    mag  = neg ? ((64'd1 << W) - 64'(x)) : 64'(x);
    r.ovf = 0;
    r.acc = 0;
    if (mag == 0) begin
      r.val  = '0;
      r.inex = 0;
      r.lat  = 2;
      return r;
    end
    lead = 0;
    for (int i = 0; i < 64; i++) if ((mag >> i) & 64'd1) lead = i;
    if (lead <= MW) begin
      field  = mag;
      r.inex = 0;
      r.lat  = (W - 1 - MW) + 2;
    end else begin
      sft   = lead - MW;
      kept  = mag >> sft;
      rem   = mag & ((64'd1 << sft) - 1);
      half  = 64'd1 << (sft - 1);
      field = (64'(sft) << MW) + kept;
      if (rem > half || (rem == half && (kept & 64'd1) == 1)) field = field + 1;
      r.inex = (rem != 0);
      r.lat  = (W - 1 - lead) + 2;
    end
    if (field >= (EMAX << MW)) begin
      r.ovf = 1;
      r.val = {neg, {EW{1'b1}}, {MW{1'b0}}};
    end else begin
      r.val = {neg, field[FW-2:0]};
    end
    return r;
  endfunction

  task automatic send(input logic [W-1:0] x, input bit expect_out);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!bus_if.in_ready_o && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_if.in_ready_o) begin
      chk("send_ready_timeout", 0, 1);
      return;
    end
    bus_if.fixed_point_value_i = x;
    bus_if.in_valid_i          = 1'b1;
    e     = model(x);
    e.acc = cyc + 1;
    if (expect_out) q.push_back(e);
    @(negedge clk);
    bus_if.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_size", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen    = 0;
      chk_rdy = 0;
      hold    = 0;
    end else begin
      if (chk_rdy) begin
        chk("in_ready_after_pop", bus_if.in_ready_o, 1);
        chk_rdy = 0;
      end
      if (bus_if.out_valid_o) begin
        if (!seen) begin
          seen = 1;
          rise = cyc;
          if (hold_req) hold = 5;
        end
        chk("in_ready_low_in_done", bus_if.in_ready_o, 0);
        if (hold > 0) begin
          bus_if.out_ready_i = 1'b0;
          hold--;
        end else begin
          bus_if.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
          bus_if.out_ready_i = 1'b1;
          seen = 0;
        end else begin
          chk("value", bus_if.float_point_value_o, q[0].val);
          if (bus_if.out_ready_i) begin
            mon_e = q.pop_front();
            chk("inexact", bus_if.inexact_flag_o, mon_e.inex);
            chk("overflow", bus_if.overflow_flag_o, mon_e.ovf);
            chk("latency", rise - mon_e.acc, mon_e.lat);
            seen    = 0;
            chk_rdy = 1;
          end
        end
      end else begin
        bus_if.out_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] dir_vec [12];
  logic [63:0]  rnd;

  initial begin
    bus_if.in_valid_i          = 1'b0;
    bus_if.fixed_point_value_i = '0;
    bus_if.out_ready_i         = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", bus_if.in_ready_o, 1);
    chk("reset_out_valid", bus_if.out_valid_o, 0);
    chk("reset_value", bus_if.float_point_value_o, 0);
    chk("reset_inexact", bus_if.inexact_flag_o, 0);
    chk("reset_overflow", bus_if.overflow_flag_o, 0);
    rst = 1'b0;

    dir_vec[0]  = 40'h0001000000;
    dir_vec[1]  = 40'hFFFF000000;
    dir_vec[2]  = 40'h0000000001;
    dir_vec[3]  = 40'h0000000000;
    dir_vec[4]  = 40'hFFFFFFFFFF;
    dir_vec[5]  = 40'h0000000803;
    dir_vec[6]  = 40'h0000000801;
    dir_vec[7]  = 40'h00000007FF;
    dir_vec[8]  = 40'h7FFFFFFFFF;
    dir_vec[9]  = 40'h8000000000;
    dir_vec[10] = 40'h0000000400;
    dir_vec[11] = 40'h0000000C00;
    for (int i = 0; i < 12; i++) send(dir_vec[i], 1'b1);
    wait_drain();

    hold_req = 1;
    send(40'h0000000803, 1'b1);
    begin : wait_valid
      int n;
      n = 0;
      while (!bus_if.out_valid_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("backpressure_valid_seen", bus_if.out_valid_o, 1);
    end
    bus_if.fixed_point_value_i = 40'h0001000000;
    bus_if.in_valid_i          = 1'b1;
    @(negedge clk);
    bus_if.in_valid_i = 1'b0;
    wait_drain();
    hold_req = 0;

    send(40'h0001000000, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_out_valid", bus_if.out_valid_o, 0);
    chk("midreset_in_ready", bus_if.in_ready_o, 1);
    chk("midreset_value", bus_if.float_point_value_o, 0);
    chk("midreset_flags", {bus_if.inexact_flag_o, bus_if.overflow_flag_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(40'h0000000400, 1'b1);
    wait_drain();

    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      rnd = {$urandom, $urandom};
      rnd = rnd[W-1:0] >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 1) == 1) rnd = (64'd1 << W) - rnd;
      send(rnd[W-1:0], 1'b1);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
